// File: rtl/uart_pkg.sv
// Shared constants for the UART/ALU sequencer: state encoding,
// default widths and the ALU opcode map.
package uart_pkg;

   localparam int DBIT_DFLT  = 8;
   localparam int NB_OP_DFLT = 6;

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      LATCH   = 3'd3,
      SEND    = 3'd4,
      WAIT_TX = 3'd5
   } state_e;

   localparam logic [5:0] ADD = 6'b100000;
   localparam logic [5:0] SUB = 6'b100010;
   localparam logic [5:0] AND = 6'b100100;
   localparam logic [5:0] OR  = 6'b100101;
   localparam logic [5:0] XOR = 6'b100110;
   localparam logic [5:0] SRA = 6'b000011;
   localparam logic [5:0] SRL = 6'b000010;
   localparam logic [5:0] NOR = 6'b100111;

endpackage

// File: rtl/intf_timeout_cnt.sv
// Inter-byte timeout counter; only built when INTF_TIMEOUT_EN is defined.
// Counts while enabled, restarts on clr, flags the terminal cycle.
module intf_timeout_cnt #(
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tc
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr || !en) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = en && (cnt_q == TC_VAL);

endmodule

// File: rtl/uart_alu_intf.sv
// Sequencer: collects A, B, opcode from the UART, latches the ALU result
// and sends it back. Optional inter-byte timeout via INTF_TIMEOUT_EN.
module uart_alu_intf
   import uart_pkg::*;
#(
   parameter int DBIT        = DBIT_DFLT,
   parameter int NB_OP       = NB_OP_DFLT,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_done_tick,
   input  logic [DBIT-1:0]  rx_data,
   input  logic             tx_done_tick,
   input  logic [DBIT-1:0]  alu_result,
   output logic [DBIT-1:0]  alu_a,
   output logic [DBIT-1:0]  alu_b,
   output logic [NB_OP-1:0] alu_op,
   output logic             tx_start,
   output logic [DBIT-1:0]  tx_data,
   output logic             busy,
   output logic             err_timeout
);

   state_e           state_q, state_d;
   logic [DBIT-1:0]  alu_a_q, alu_a_d;
   logic [DBIT-1:0]  alu_b_q, alu_b_d;
   logic [NB_OP-1:0] alu_op_q, alu_op_d;
   logic [DBIT-1:0]  tx_data_q, tx_data_d;
   logic             tx_start_q, tx_start_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             tmo;

`ifdef INTF_TIMEOUT_EN
   logic cnt_en;

   assign cnt_en = (state_q == WAIT_B) || (state_q == WAIT_OP);

   // Outside the enabled states the counter sits at zero, so clearing
   // on each accepted byte also covers every state entry.
   intf_timeout_cnt #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .clk  (clk),
      .reset(reset),
      .en   (cnt_en),
      .clr  (rx_done_tick),
      .tc   (tmo)
   );
`else
   logic unused_cfg;

   assign unused_cfg = (TIMEOUT_CYC == 0);
   assign tmo        = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      tx_data_d  = tx_data_q;
      busy_d     = busy_q;
      tx_start_d = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         WAIT_A: begin
            if (rx_done_tick) begin
               alu_a_d = rx_data;
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            if (rx_done_tick) begin
               alu_b_d = rx_data;
               state_d = WAIT_OP;
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = WAIT_A;
            end
         end
         WAIT_OP: begin
            if (rx_done_tick) begin
               alu_op_d = rx_data[NB_OP-1:0];
               busy_d   = 1'b1;
               state_d  = LATCH;
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = WAIT_A;
            end
         end
         LATCH: begin
            tx_data_d = alu_result;
            state_d   = SEND;
         end
         SEND: begin
            tx_start_d = 1'b1;
            state_d    = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_done_tick) begin
               busy_d  = 1'b0;
               state_d = WAIT_A;
            end
         end
         default: state_d = WAIT_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= WAIT_A;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign busy        = busy_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_alu_intf.sv
// Bench for uart_alu_intf: directed frames plus random frames against
// a behavioural ALU/frame model.
module tb_uart_alu_intf;
   import uart_pkg::*;

   localparam int DBIT  = 8;
   localparam int NB_OP = 6;
   localparam int TCYC  = 100;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             rx_done_tick = 1'b0;
   logic [DBIT-1:0]  rx_data = '0;
   logic             tx_done_tick = 1'b0;
   logic [DBIT-1:0]  alu_result;
   logic [DBIT-1:0]  alu_a, alu_b, tx_data;
   logic [NB_OP-1:0] alu_op;
   logic             tx_start, busy, err_timeout;

   int vectors = 0;
   int miscompares = 0;
   int starts = 0;
   int errs = 0;

   uart_alu_intf #(
      .DBIT(DBIT), .NB_OP(NB_OP), .TIMEOUT_CYC(TCYC)
   ) dut (
      .clk(clk), .reset(reset),
      .rx_done_tick(rx_done_tick), .rx_data(rx_data),
      .tx_done_tick(tx_done_tick), .alu_result(alu_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .tx_start(tx_start), .tx_data(tx_data),
      .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_ref(
      input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      case (op)
         ADD: return a + b;
         SUB: return a - b;
         AND: return a & b;
         OR:  return a | b;
         XOR: return a ^ b;
         SRA: return 8'($signed(a) >>> b);
         SRL: return a >> b;
         NOR: return ~(a | b);
         default: return 8'h00;
      endcase
   endfunction

   // Stand-in for the combinational ALU the block sits in front of
   always_comb alu_result = alu_ref(alu_a, alu_b, alu_op);

   always @(posedge clk) begin
      if (tx_start) starts++;
      if (err_timeout) errs++;
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_done_tick = 1'b1;
      @(negedge clk);
      rx_done_tick = 1'b0;
   endtask

   // mode 0: plain; 1: stray byte in WAIT_TX; 2: rx together with tx_done
   task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input int gap,
                            input int mode, input string nm);
      logic [7:0] exp;
      int s0;
      s0 = starts;
      exp = alu_ref(a, b, op[5:0]);
      send_byte(a);
      send_byte(b);
      send_byte(op);
      vectors++;
      if (alu_a !== a || alu_b !== b || alu_op !== op[5:0]) begin
         miscompares++;
         $display("FAIL %s operands: got %h %h %h want %h %h %h",
                  nm, alu_a, alu_b, alu_op, a, b, op[5:0]);
      end
      vectors++;
      if (busy !== 1'b1 || tx_start !== 1'b0) begin
         miscompares++;
         $display("FAIL %s busy@N+1: busy=%b start=%b want 1 0",
                  nm, busy, tx_start);
      end
      @(negedge clk);
      vectors++;
      if (tx_data !== exp || tx_start !== 1'b0) begin
         miscompares++;
         $display("FAIL %s tx_data@N+2: got %h start=%b want %h 0",
                  nm, tx_data, tx_start, exp);
      end
      @(negedge clk);
      vectors++;
      if (tx_start !== 1'b1) begin
         miscompares++;
         $display("FAIL %s tx_start@N+3: got %b want 1", nm, tx_start);
      end
      @(negedge clk);
      vectors++;
      if (tx_start !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL %s after pulse: start=%b busy=%b want 0 1",
                  nm, tx_start, busy);
      end
      repeat (gap) @(negedge clk);
      if (mode == 1) begin
         send_byte(8'hAA);
         vectors++;
         if (alu_a !== a || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s drop: alu_a=%h busy=%b want %h 1",
                     nm, alu_a, busy, a);
         end
      end
      @(negedge clk);
      tx_done_tick = 1'b1;
      if (mode == 2) begin
         rx_data = 8'h77;
         rx_done_tick = 1'b1;
      end
      @(negedge clk);
      tx_done_tick = 1'b0;
      rx_done_tick = 1'b0;
      vectors++;
      if (busy !== 1'b0 || alu_a !== a) begin
         miscompares++;
         $display("FAIL %s done: busy=%b alu_a=%h want 0 %h",
                  nm, busy, alu_a, a);
      end
      vectors++;
      if (starts != s0 + 1) begin
         miscompares++;
         $display("FAIL %s pulses: got %0d want 1", nm, starts - s0);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, err_timeout}
          !== '0) begin
         miscompares++;
         $display("FAIL reset: a=%h b=%h op=%h tx=%h st=%b bz=%b er=%b",
                  alu_a, alu_b, alu_op, tx_data, tx_start, busy, err_timeout);
      end
   endtask

   task automatic test_add;
      run_frame(8'h05, 8'h03, 8'h20, 2, 0, "add");
      vectors++;
      if (tx_data !== 8'h08) begin
         miscompares++;
         $display("FAIL add_const: got %h want 08", tx_data);
      end
   endtask

   task automatic test_sub;
      run_frame(8'h03, 8'h05, 8'h22, 0, 0, "sub");
      vectors++;
      if (tx_data !== 8'hFE) begin
         miscompares++;
         $display("FAIL sub_const: got %h want FE", tx_data);
      end
   endtask

   task automatic test_drop;
      run_frame(8'h12, 8'h34, {2'b00, XOR}, 3, 1, "drop");
      run_frame(8'h0F, 8'hF0, 8'h24, 1, 0, "after_drop");
      vectors++;
      if (tx_data !== 8'h00) begin
         miscompares++;
         $display("FAIL and_const: got %h want 00", tx_data);
      end
      run_frame(8'h81, 8'h02, {2'b00, SRA}, 1, 2, "coincident");
      run_frame(8'h81, 8'h02, {2'b00, SRL}, 0, 0, "after_coinc");
   endtask

   task automatic test_mid_reset;
      int s0;
      s0 = starts;
      send_byte(8'h11);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++;
      if (alu_a !== 8'h00 || busy !== 1'b0 || tx_data !== 8'h00) begin
         miscompares++;
         $display("FAIL mid_reset: a=%h busy=%b tx=%h want 00 0 00",
                  alu_a, busy, tx_data);
      end
      repeat (5) @(negedge clk);
      vectors++;
      if (starts != s0) begin
         miscompares++;
         $display("FAIL mid_reset_start: got %0d pulses want 0",
                  starts - s0);
      end
      run_frame(8'h22, 8'h33, {2'b00, OR}, 1, 0, "post_reset");
   endtask

   task automatic test_op_strip;
      run_frame(8'h40, 8'h01, 8'hE0, 4, 0, "strip");
      vectors++;
      if (alu_op !== 6'h20 || tx_data !== 8'h41) begin
         miscompares++;
         $display("FAIL strip_const: op=%h tx=%h want 20 41",
                  alu_op, tx_data);
      end
   endtask

   task automatic test_back_to_back;
      logic [5:0] ops [8];
      ops = '{ADD, SUB, AND, OR, XOR, SRA, SRL, NOR};
      for (int i = 0; i < 24; i++) begin
         logic [7:0] a, b, op;
         a = 8'($urandom);
         b = (i % 3 == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
         op = {2'($urandom), ops[$urandom_range(0, 7)]};
         if (i % 4 == 1) begin
            // stray tx_done while idle must be ignored
            @(negedge clk);
            tx_done_tick = 1'b1;
            @(negedge clk);
            tx_done_tick = 1'b0;
         end
         run_frame(a, b, op, $urandom_range(0, 5),
                   $urandom_range(0, 2), "random");
      end
   endtask

   task automatic test_timeout;
      int e0;
      e0 = errs;
      send_byte(8'h5A);
      repeat (TCYC + 10) @(negedge clk);
`ifdef INTF_TIMEOUT_EN
      vectors++;
      if (errs != e0 + 1) begin
         miscompares++;
         $display("FAIL timeout_pulse: got %0d want 1", errs - e0);
      end
      run_frame(8'h09, 8'h04, {2'b00, SUB}, 1, 0, "after_timeout");
`else
      vectors++;
      if (errs != e0) begin
         miscompares++;
         $display("FAIL no_timeout: got %0d pulses want 0", errs - e0);
      end
      send_byte(8'h06);
      send_byte({2'b00, ADD});
      repeat (3) @(negedge clk);
      vectors++;
      if (alu_a !== 8'h5A || tx_data !== 8'h60) begin
         miscompares++;
         $display("FAIL wait_forever: a=%h tx=%h want 5A 60",
                  alu_a, tx_data);
      end
      @(negedge clk);
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      run_frame(8'h09, 8'h04, {2'b00, SUB}, 1, 0, "after_wait");
`endif
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_drop();
      test_mid_reset();
      test_op_strip();
      test_back_to_back();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
